bp_fe_rollback_queue: RTL and testbench

- FIFO between front end (producer) and back-end scheduler (consumer); carries fe_queue packets.
- Implements the consumer-controlled speculative protocol: yumi, deq, roll and clr.
- Entries read by the BE stay resident until committed with deq, so a roll can replay them.
- Sits at the FE/BE boundary and drives the FE-queue consumer port of the back end.

---
 rtl/bp_fe_rollback_queue.sv | 86 ++++++++
 tb/tb_bp_fe_rollback_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_rollback_queue.sv
// FE-to-BE packet queue with speculative reads: entries stay resident until
// committed with deq, so a roll can replay them and a clr can drop unread ones.
module bp_fe_rollback_queue #(
  parameter int bp_params_p      = 0,
  parameter int fe_queue_width_p = 32,
  parameter int els_p            = 8,
  localparam int fe_queue_width_lp = fe_queue_width_p,
  localparam int ptr_width_lp      = $clog2(els_p) + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,

  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,

  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  input  logic                         fe_queue_deq_i,
  input  logic                         fe_queue_roll_i,
  input  logic                         fe_queue_clr_i,
  output logic [ptr_width_lp-1:0]      fe_queue_count_o
);

  localparam int idx_width_lp = ptr_width_lp - 1;
  localparam logic [ptr_width_lp-1:0] els_lp = ptr_width_lp'(els_p);

  logic [fe_queue_width_lp-1:0] mem_q [els_p];

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  logic [ptr_width_lp-1:0] rptr_y;
  logic                    enq;
  logic                    yumi_eff;

  assign fe_queue_count_o = wptr_q - cptr_q;
  assign fe_queue_ready_o = ~reset_i & (fe_queue_count_o != els_lp);
  assign fe_queue_v_o     = (rptr_q != wptr_q);
  assign fe_queue_o       = mem_q[rptr_q[idx_width_lp-1:0]];

  assign enq      = fe_queue_v_i & fe_queue_ready_o;
  assign yumi_eff = fe_queue_yumi_i & ~fe_queue_roll_i;

  // Order matters: yumi, then deq commits it, then roll rewinds, then clr trims.
  always_comb begin
    rptr_y = rptr_q + ptr_width_lp'(yumi_eff);
    cptr_d = fe_queue_deq_i  ? rptr_y : cptr_q;
    rptr_d = fe_queue_roll_i ? cptr_d : rptr_y;
    wptr_d = fe_queue_clr_i  ? rptr_d : (wptr_q + ptr_width_lp'(enq));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  // Storage is not reset; a write dropped by clr lands in a slot beyond wptr.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[idx_width_lp-1:0]] <= fe_queue_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o))
        else $error("bp_fe_rollback_queue: yumi without valid");
      assert ((rptr_q - cptr_q) <= (wptr_q - cptr_q))
        else $error("bp_fe_rollback_queue: read pointer beyond write pointer");
      assert (fe_queue_count_o <= els_lp)
        else $error("bp_fe_rollback_queue: count exceeds depth");
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_rollback_queue.sv
// Directed bench for bp_fe_rollback_queue (depth 4) with a queue-based
// scoreboard of resident entries and a read index for the speculative pointer.
module tb_bp_fe_rollback_queue;

  localparam int W   = 16;
  localparam int ELS = 4;
  localparam int PW  = $clog2(ELS) + 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [W-1:0]  fe_queue_i;
  logic          fe_queue_v_i;
  logic          fe_queue_ready_o;
  logic [W-1:0]  fe_queue_o;
  logic          fe_queue_v_o;
  logic          fe_queue_yumi_i;
  logic          fe_queue_deq_i;
  logic          fe_queue_roll_i;
  logic          fe_queue_clr_i;
  logic [PW-1:0] fe_queue_count_o;

  bp_fe_rollback_queue #(.fe_queue_width_p(W), .els_p(ELS)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i),
    .fe_queue_deq_i(fe_queue_deq_i), .fe_queue_roll_i(fe_queue_roll_i),
    .fe_queue_clr_i(fe_queue_clr_i), .fe_queue_count_o(fe_queue_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: every resident entry in order; rd = number already read.
  logic [W-1:0] resident[$];
  int           rd;
  int           tests;
  int           fails;

  localparam logic [W-1:0] PA = 16'hA0A0, PB = 16'hB1B1, PC = 16'hC2C2,
                           PD = 16'hD3D3, PE = 16'hE4E4, PF = 16'hF5F5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":v"}, 32'(fe_queue_v_o), 32'(rd < resident.size()));
    chk({tag, ":count"}, 32'(fe_queue_count_o), 32'(resident.size()));
    chk({tag, ":ready"}, 32'(fe_queue_ready_o), 32'(resident.size() != ELS));
    if (rd < resident.size())
      chk({tag, ":data"}, 32'(fe_queue_o), 32'(resident[rd]));
  endtask

  task automatic idle_inputs();
    fe_queue_i = '0; fe_queue_v_i = 0; fe_queue_yumi_i = 0;
    fe_queue_deq_i = 0; fe_queue_roll_i = 0; fe_queue_clr_i = 0;
  endtask

  // One cycle of stimulus: check pre-edge state, apply the model, clock.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                      input logic y, input logic dq, input logic rl, input logic cl);
    bit hs;
    @(negedge clk_i);
    fe_queue_i = d; fe_queue_v_i = v; fe_queue_yumi_i = y;
    fe_queue_deq_i = dq; fe_queue_roll_i = rl; fe_queue_clr_i = cl;
    #1;
    check_model(tag);
    hs = v && (resident.size() != ELS);
    if (y && !rl) begin
      if (rd < resident.size()) begin
        chk({tag, ":yumi_data"}, 32'(fe_queue_o), 32'(resident[rd]));
        rd++;
      end else begin
        chk({tag, ":yumi_avail"}, 32'(rd), 32'(resident.size() + 1));
      end
    end
    if (dq) begin
      repeat (rd) void'(resident.pop_front());
      rd = 0;
    end
    if (rl) rd = 0;
    if (cl) begin
      while (resident.size() > rd) void'(resident.pop_back());
    end else if (hs) begin
      resident.push_back(d);
    end
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic peek(input string tag, input logic [31:0] obs_sel, input logic [31:0] exp);
    @(negedge clk_i);
    #1;
    case (obs_sel)
      0: chk(tag, 32'(fe_queue_v_o), exp);
      1: chk(tag, 32'(fe_queue_count_o), exp);
      2: chk(tag, 32'(fe_queue_ready_o), exp);
      default: chk(tag, 32'(fe_queue_o), exp);
    endcase
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_i);
    reset_i = 1;
    idle_inputs();
    #1;
    chk("rst:ready_during", 32'(fe_queue_ready_o), 32'd0);
    repeat (cycles) @(posedge clk_i);
    #1;
    resident.delete();
    rd = 0;
    @(negedge clk_i);
    reset_i = 0;
    #1;
    chk("rst:v_after", 32'(fe_queue_v_o), 32'd0);
    chk("rst:count_after", 32'(fe_queue_count_o), 32'd0);
    chk("rst:ready_after", 32'(fe_queue_ready_o), 32'd1);
  endtask

  initial begin
    tests = 0; fails = 0; rd = 0;
    reset_i = 1;
    idle_inputs();

    // Power-up reset: state is checked while reset is still asserted.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("rst0:ready", 32'(fe_queue_ready_o), 32'd0);
    chk("rst0:v", 32'(fe_queue_v_o), 32'd0);
    chk("rst0:count", 32'(fe_queue_count_o), 32'd0);
    reset_i = 0;
    #1;
    chk("rst0:ready_release", 32'(fe_queue_ready_o), 32'd1);

    // Fill to full; E stalls.
    step("fill_a", 1, PA, 0, 0, 0, 0);
    peek("fill:a_visible", 3, 32'(PA));
    step("fill_b", 1, PB, 0, 0, 0, 0);
    step("fill_c", 1, PC, 0, 0, 0, 0);
    step("fill_d", 1, PD, 0, 0, 0, 0);
    peek("fill:ready_full", 2, 32'd0);
    step("fill_e_stall", 1, PE, 0, 0, 0, 0);
    peek("fill:count4", 1, 32'd4);

    // Read two, roll back.
    step("roll_ya", 0, '0, 1, 0, 0, 0);
    step("roll_yb", 0, '0, 1, 0, 0, 0);
    peek("roll:o_c_before", 3, 32'(PC));
    step("roll", 0, '0, 0, 0, 1, 0);
    peek("roll:o_a", 3, 32'(PA));
    peek("roll:count4", 1, 32'd4);
    peek("roll:ready0", 2, 32'd0);

    // Yumi with deq frees one slot; a later roll stays on B.
    step("deq_ya", 0, '0, 1, 1, 0, 0);
    peek("deq:count3", 1, 32'd3);
    peek("deq:ready1", 2, 32'd1);
    peek("deq:o_b", 3, 32'(PB));
    step("deq_roll", 0, '0, 0, 0, 1, 0);
    peek("deq_roll:o_b", 3, 32'(PB));
    step("deq_idle", 0, '0, 0, 0, 0, 0);

    // Clear unread, roll, commit.
    do_reset(1);
    step("clr_ea", 1, PA, 0, 0, 0, 0);
    step("clr_eb", 1, PB, 0, 0, 0, 0);
    step("clr_ec", 1, PC, 0, 0, 0, 0);
    step("clr_ya", 0, '0, 1, 0, 0, 0);
    step("clr", 1, PE, 0, 0, 0, 1);
    peek("clr:v0", 0, 32'd0);
    peek("clr:count1", 1, 32'd1);
    step("clr_roll", 0, '0, 0, 0, 1, 0);
    peek("clr_roll:v1", 0, 32'd1);
    peek("clr_roll:o_a", 3, 32'(PA));
    step("clr_commit", 0, '0, 1, 1, 0, 0);
    peek("clr_commit:count0", 1, 32'd0);
    peek("clr_commit:v0", 0, 32'd0);

    // Streaming through several pointer wraps.
    step("stream_0", 1, 16'd0, 0, 0, 0, 0);
    for (int k = 1; k < 12; k++) begin
      step($sformatf("stream_%0d", k), 1, 16'(k), 1, 1, 0, 0);
      chk("stream:count_le1", 32'(fe_queue_count_o <= 1), 32'd1);
    end
    step("stream_last", 0, '0, 1, 1, 0, 0);
    peek("stream:drained", 1, 32'd0);

    // Reset mid-operation drops everything.
    step("mid_ea", 1, PA, 0, 0, 0, 0);
    step("mid_eb", 1, PB, 0, 0, 0, 0);
    step("mid_ec", 1, PC, 0, 0, 0, 0);
    step("mid_ya", 0, '0, 1, 0, 0, 0);
    do_reset(1);
    step("mid_ef", 1, PF, 0, 0, 0, 0);
    peek("mid:o_f", 3, 32'(PF));
    peek("mid:count1", 1, 32'd1);
    step("mid_tail", 0, '0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
